// File: rtl/accum_seq_16.sv
// rtl/accum_seq_16.sv - multi-operand accumulator built around a 16-bit carry-lookahead adder
// Streams operands through one adder and reports the final sum plus a saturating carry count.

module CLA_16_bit_ripple (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  // Carries inside one nibble from its generate/propagate bits and carry-in
  function automatic logic [3:0] cla4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
    logic [3:0] co;
    co[0] = gi[0] | (pi[0] & ci);
    co[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    co[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    co[3] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0])
          | (pi[3] & pi[2] & pi[1] & pi[0] & ci);
    return co;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead within each nibble, nibble carries ripple into the next
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[4*i+1 +: 4] = cla4(g[4*i +: 4], p[4*i +: 4], c[4*i]);
    end
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

module accum_seq_16 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carry_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      acc;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] remaining;
  logic [15:0]      add_sum;
  logic             add_cout;
  logic             accept;

  CLA_16_bit_ripple u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept = (state == ACCUM) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && (remaining == CNT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result registers persist through IDLE until the next start clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      carry_cnt <= '0;
      remaining <= '0;
    end else if ((state == IDLE) && start) begin
      acc       <= '0;
      carry_cnt <= '0;
      remaining <= len;
    end else if (accept) begin
      acc       <= add_sum;
      remaining <= remaining - CNT_W'(1);
      if (add_cout && (carry_cnt != {CNT_W{1'b1}})) begin
        carry_cnt <= carry_cnt + CNT_W'(1);
      end
    end
  end

  assign out_sum       = acc;
  assign out_carry_cnt = carry_cnt;

endmodule
